// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the CPU-to-cache request arbiter:
// FSM state encoding and kseg0/kseg1 translation constants.
package mem_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_D_REQ,
    ST_D_WAIT,
    ST_I_REQ,
    ST_I_WAIT,
    ST_DONE
  } arb_state_e;

  localparam logic [2:0]  UNCACHED_SEG_DEF = 3'b101;
  localparam logic [1:0]  KSEG01           = 2'b10;
  localparam logic [31:0] XLATE_MASK       = 32'h1FFF_FFFF;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Downstream cache/uncached request channel between the arbiter (master)
// and the cache/AXI bridge (slave).
interface mem_req_arbiter_if #(
  parameter int DATA_W = 32
);

  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic [DATA_W/8-1:0]   mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_is_cache;
  logic                  mem_ready;
  logic                  mem_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_wen, mem_wdata, mem_is_cache,
    input  mem_ready, mem_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_wen, mem_wdata, mem_is_cache,
    output mem_ready, mem_valid, mem_rdata
  );

endinterface

// File: rtl/mem_req_arbiter_addr_xlate.sv
// Combinational virtual-to-physical translation: kseg0/kseg1 fold onto the
// low 512 MB, everything else passes through; flags the uncached segment.
module addr_xlate
  import mem_if_pkg::*;
#(
  parameter logic [2:0] UNCACHED_SEG = UNCACHED_SEG_DEF
) (
  input  logic [31:0] vaddr_i,
  output logic [31:0] paddr_o,
  output logic        is_cache_o
);

  assign paddr_o    = (vaddr_i[31:30] == KSEG01) ? (vaddr_i & XLATE_MASK) : vaddr_i;
  assign is_cache_o = (vaddr_i[31:29] != UNCACHED_SEG);

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises one fetch and at most one data access per pipeline step onto a
// single downstream request channel, buffering read data and holding stall.
module mem_req_arbiter
  import mem_if_pkg::*;
#(
  parameter int         DATA_W       = 32,
  parameter logic [2:0] UNCACHED_SEG = UNCACHED_SEG_DEF,
  parameter bit         DATA_FIRST   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                inst_req_i,
  input  logic [31:0]         inst_vaddr_i,
  output logic [DATA_W-1:0]   inst_rdata_o,
  input  logic                data_ren_i,
  input  logic [DATA_W/8-1:0] data_wen_i,
  input  logic [31:0]         data_vaddr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                stall_o,
  mem_req_arbiter_if.master   mem_bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic              stall_q, mem_req_q;
  logic              drop_q, drop_d;
  logic              d_pend_q, d_pend_d;
  logic              d_load_q, d_load_d;
  logic              i_pend_q, i_pend_d;
  logic [BE_W-1:0]   d_wen_q, d_wen_d;
  logic [31:0]       d_vaddr_q, d_vaddr_d;
  logic [31:0]       i_vaddr_q, i_vaddr_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic        data_op, sel_data, in_req, in_wait, complete, kill;
  logic [31:0] sel_vaddr, paddr;
  logic        is_cache;

  assign data_op   = data_ren_i || (data_wen_i != '0);
  assign sel_data  = (state_q == ST_D_REQ) || (state_q == ST_D_WAIT);
  assign in_req    = (state_q == ST_D_REQ) || (state_q == ST_I_REQ);
  assign in_wait   = (state_q == ST_D_WAIT) || (state_q == ST_I_WAIT);
  assign complete  = (in_req && mem_bus.mem_ready && mem_bus.mem_valid) ||
                     (in_wait && mem_bus.mem_valid);
  assign kill      = drop_q || flush_i;
  assign sel_vaddr = sel_data ? d_vaddr_q : i_vaddr_q;

  always_comb begin
    state_d   = state_q;
    d_pend_d  = d_pend_q;
    d_load_d  = d_load_q;
    i_pend_d  = i_pend_q;
    d_wen_d   = d_wen_q;
    d_vaddr_d = d_vaddr_q;
    i_vaddr_d = i_vaddr_q;
    d_wdata_d = d_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    drop_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!flush_i) begin
          // A simultaneous load and store keeps only the load.
          d_pend_d  = data_op;
          d_load_d  = data_ren_i;
          d_wen_d   = data_ren_i ? '0 : data_wen_i;
          d_vaddr_d = data_vaddr_i;
          d_wdata_d = data_wdata_i;
          i_pend_d  = inst_req_i;
          i_vaddr_d = inst_vaddr_i;
          if (data_op && (DATA_FIRST || !inst_req_i)) state_d = ST_D_REQ;
          else if (inst_req_i)                        state_d = ST_I_REQ;
          else                                        state_d = ST_DONE;
        end
      end
      ST_D_REQ, ST_I_REQ: begin
        if (mem_bus.mem_ready) state_d = sel_data ? ST_D_WAIT : ST_I_WAIT;
        else if (flush_i)      state_d = ST_IDLE;
      end
      ST_D_WAIT, ST_I_WAIT: state_d = state_q;
      ST_DONE:              state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase

    // Completion overrides the REQ/WAIT transitions above.
    if (complete) begin
      if (kill) begin
        state_d = ST_IDLE;
      end else begin
        if (sel_data) begin
          d_pend_d = 1'b0;
          if (d_load_q) d_rdata_d = mem_bus.mem_rdata;
        end else begin
          i_pend_d  = 1'b0;
          i_rdata_d = mem_bus.mem_rdata;
        end
        if (sel_data ? i_pend_q : d_pend_q) state_d = sel_data ? ST_I_REQ : ST_D_REQ;
        else                                state_d = ST_DONE;
      end
    end

    if ((state_d == ST_D_REQ) || (state_d == ST_I_REQ) ||
        (state_d == ST_D_WAIT) || (state_d == ST_I_WAIT))
      drop_d = drop_q || flush_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stall_q   <= 1'b1;
      mem_req_q <= 1'b0;
      drop_q    <= 1'b0;
      d_pend_q  <= 1'b0;
      d_load_q  <= 1'b0;
      i_pend_q  <= 1'b0;
      d_wen_q   <= '0;
      d_vaddr_q <= '0;
      i_vaddr_q <= '0;
      d_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      stall_q   <= (state_d != ST_DONE);
      mem_req_q <= (state_d == ST_D_REQ) || (state_d == ST_I_REQ);
      drop_q    <= drop_d;
      d_pend_q  <= d_pend_d;
      d_load_q  <= d_load_d;
      i_pend_q  <= i_pend_d;
      d_wen_q   <= d_wen_d;
      d_vaddr_q <= d_vaddr_d;
      i_vaddr_q <= i_vaddr_d;
      d_wdata_q <= d_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  addr_xlate #(
    .UNCACHED_SEG(UNCACHED_SEG)
  ) u_xlate (
    .vaddr_i    (sel_vaddr),
    .paddr_o    (paddr),
    .is_cache_o (is_cache)
  );

  assign mem_bus.mem_req      = mem_req_q;
  assign mem_bus.mem_addr     = paddr;
  assign mem_bus.mem_is_cache = is_cache;
  assign mem_bus.mem_wen      = sel_data ? d_wen_q : '0;
  assign mem_bus.mem_wdata    = d_wdata_q;

  assign stall_o      = stall_q;
  assign inst_rdata_o = i_rdata_q;
  assign data_rdata_o = d_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomised bench for mem_req_arbiter: a transaction-list reference model
// predicts bus requests, step length and buffered read data.
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        ireq, dren, stall;
  logic [3:0]  dwen;
  logic [31:0] iva, dva, dwd, ird, drd;
  logic        b_ireq, b_dren, b_stall;
  logic [3:0]  b_dwen;
  logic [31:0] b_iva, b_dva, b_dwd, b_ird, b_drd;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_ird, exp_drd;

  typedef struct {
    bit          is_data;
    bit          is_load;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    bit          cache;
    int          rdy;
    int          vld;
  } txn_t;

  mem_req_arbiter_if #(.DATA_W(32)) bus_a ();
  mem_req_arbiter_if #(.DATA_W(32)) bus_b ();

  mem_req_arbiter #(.DATA_W(32), .UNCACHED_SEG(3'b101), .DATA_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush),
    .inst_req_i(ireq), .inst_vaddr_i(iva), .inst_rdata_o(ird),
    .data_ren_i(dren), .data_wen_i(dwen), .data_vaddr_i(dva), .data_wdata_i(dwd),
    .data_rdata_o(drd), .stall_o(stall), .mem_bus(bus_a)
  );

  mem_req_arbiter #(.DATA_W(32), .UNCACHED_SEG(3'b101), .DATA_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush_i(1'b0),
    .inst_req_i(b_ireq), .inst_vaddr_i(b_iva), .inst_rdata_o(b_ird),
    .data_ren_i(b_dren), .data_wen_i(b_dwen), .data_vaddr_i(b_dva), .data_wdata_i(b_dwd),
    .data_rdata_o(b_drd), .stall_o(b_stall), .mem_bus(bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] ref_paddr(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
    if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
    return va;
  endfunction

  function automatic bit ref_cached(input logic [31:0] va);
    return !(va >= 32'hA000_0000 && va < 32'hC000_0000);
  endfunction

  function automatic logic [31:0] rnd_va();
    return {3'($urandom_range(7, 0)), 29'($urandom)};
  endfunction

  task automatic give_valid(input txn_t h);
    logic [31:0] rd;
    rd = $urandom;
    bus_a.mem_valid = 1'b1;
    bus_a.mem_rdata = rd;
    if (h.is_data) begin
      if (h.is_load) exp_drd = rd;
    end else begin
      exp_ird = rd;
    end
  endtask

  // One pipeline step on instance A; bus delays drawn per transaction.
  task automatic run_step(input logic ren, input logic [3:0] wen,
                          input logic [31:0] d_va, input logic [31:0] d_wd,
                          input logic i_rq, input logic [31:0] i_va,
                          input int rmin, input int rmax, input int vmin, input int vmax,
                          output int cyc);
    txn_t q[$];
    txn_t t, h;
    int   exp_cyc, cnt, phase;
    bit   have, done;
    exp_cyc = 1;
    if (ren || wen != 4'h0) begin
      t.is_data = 1'b1; t.is_load = ren;
      t.addr = ref_paddr(d_va); t.cache = ref_cached(d_va);
      t.wen = ren ? 4'h0 : wen; t.wdata = d_wd;
      t.rdy = int'($urandom_range(rmax, rmin)); t.vld = int'($urandom_range(vmax, vmin));
      exp_cyc += t.rdy + 1 + t.vld;
      q.push_back(t);
    end
    if (i_rq) begin
      t.is_data = 1'b0; t.is_load = 1'b1;
      t.addr = ref_paddr(i_va); t.cache = ref_cached(i_va);
      t.wen = 4'h0; t.wdata = 32'h0;
      t.rdy = int'($urandom_range(rmax, rmin)); t.vld = int'($urandom_range(vmax, vmin));
      exp_cyc += t.rdy + 1 + t.vld;
      q.push_back(t);
    end
    dren = ren; dwen = wen; dva = d_va; dwd = d_wd; ireq = i_rq; iva = i_va;
    phase = 0; have = 1'b0; done = 1'b0; cyc = 0; cnt = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
      bus_a.mem_ready = 1'b0;
      bus_a.mem_valid = 1'b0;
      if (!have && q.size() > 0) begin
        h = q.pop_front();
        have = 1'b1;
      end
      if (!stall) begin
        done = 1'b1;
      end else if (!have) begin
        chk("req_low", 32'(bus_a.mem_req), 32'd0);
      end else if (phase == 0) begin
        if (bus_a.mem_req) begin
          chk("addr", bus_a.mem_addr, h.addr);
          chk("wen", 32'(bus_a.mem_wen), 32'(h.wen));
          chk("is_cache", 32'(bus_a.mem_is_cache), 32'(h.cache));
          if (h.wen != 4'h0) chk("wdata", bus_a.mem_wdata, h.wdata);
          if (h.rdy == 0) begin
            bus_a.mem_ready = 1'b1;
            if (h.vld == 0) begin
              give_valid(h);
              have = 1'b0;
            end else begin
              cnt = h.vld;
              phase = 1;
            end
          end else begin
            h.rdy--;
          end
        end
      end else begin
        chk("wait_req", 32'(bus_a.mem_req), 32'd0);
        cnt--;
        if (cnt == 0) begin
          give_valid(h);
          have = 1'b0;
          phase = 0;
        end
      end
    end
    chk("step_done", 32'(done), 32'd1);
    chk("cycles", 32'(cyc), 32'(exp_cyc));
    chk("inst_rdata", ird, exp_ird);
    chk("data_rdata", drd, exp_drd);
    dren = 1'b0; dwen = 4'h0; ireq = 1'b0;
    tick();
    chk("stall_one", 32'(stall), 32'd1);
    chk("req_after", 32'(bus_a.mem_req), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic        r_ren, r_irq;
    logic [3:0]  r_wen;
    logic [31:0] old_ird;
    logic [31:0] b_addr[$];
    bit          b_done;

    rst = 1'b1; flush = 1'b0;
    ireq = 1'b0; dren = 1'b0; dwen = 4'h0; iva = 32'h0; dva = 32'h0; dwd = 32'h0;
    b_ireq = 1'b0; b_dren = 1'b0; b_dwen = 4'h0; b_iva = 32'h0; b_dva = 32'h0; b_dwd = 32'h0;
    bus_a.mem_ready = 1'b0; bus_a.mem_valid = 1'b0; bus_a.mem_rdata = 32'h0;
    bus_b.mem_ready = 1'b1; bus_b.mem_valid = 1'b1; bus_b.mem_rdata = 32'hA5A5_0F0F;
    exp_ird = 32'h0; exp_drd = 32'h0;
    repeat (3) tick();
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_req", 32'(bus_a.mem_req), 32'd0);
    chk("rst_wen", 32'(bus_a.mem_wen), 32'd0);
    chk("rst_ird", ird, 32'h0);
    chk("rst_drd", drd, 32'h0);
    rst = 1'b0;

    // Load then fetch, best case: DONE five cycles after IDLE.
    run_step(1'b1, 4'h0, 32'hBFC0_0010, 32'h0, 1'b1, 32'h8000_0100, 0, 0, 1, 1, cyc);
    chk("best_cycles", 32'(cyc), 32'd5);

    // Store with partial byte enables; data_rdata must not move.
    run_step(1'b0, 4'b0011, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 1, 0, 2, cyc);

    // Request held three cycles without ready.
    run_step(1'b1, 4'h0, 32'h8000_3000, 32'h0, 1'b0, 32'h0, 3, 3, 1, 1, cyc);

    // Load and store together: load wins.
    run_step(1'b1, 4'hF, 32'hA000_0044, 32'h5555_AAAA, 1'b1, 32'h1000_0000, 0, 2, 0, 2, cyc);

    // Flush during I_WAIT, released before mem_valid arrives.
    old_ird = exp_ird;
    ireq = 1'b1; iva = 32'h8000_0200;
    tick(); chk("fl_req", 32'(bus_a.mem_req), 32'd1); bus_a.mem_ready = 1'b1;
    tick(); bus_a.mem_ready = 1'b0; chk("fl_wait_req", 32'(bus_a.mem_req), 32'd0); flush = 1'b1;
    tick(); flush = 1'b0; bus_a.mem_valid = 1'b1; bus_a.mem_rdata = 32'h1234_5678;
    chk("fl_stall_w", 32'(stall), 32'd1);
    tick(); bus_a.mem_valid = 1'b0; flush = 1'b1; ireq = 1'b0;
    chk("fl_stall", 32'(stall), 32'd1);
    chk("fl_req_off", 32'(bus_a.mem_req), 32'd0);
    chk("fl_ird", ird, old_ird);
    repeat (2) begin
      tick();
      chk("fl_stall_hold", 32'(stall), 32'd1);
    end
    flush = 1'b0;
    tick(); chk("fl_empty_done", 32'(stall), 32'd0);
    tick();

    for (int i = 0; i < 120; i++) begin
      r_ren = 1'($urandom_range(1, 0));
      r_wen = ($urandom_range(2, 0) == 0) ? 4'($urandom) : 4'h0;
      r_irq = 1'($urandom_range(1, 0));
      run_step(r_ren, r_wen, rnd_va(), $urandom, r_irq, rnd_va(), 0, 3, 0, 3, cyc);
    end

    // Guarantee a non-zero load buffer before the reset check.
    run_step(1'b1, 4'h0, 32'h0000_0800, 32'h0, 1'b1, 32'h0000_0900, 0, 1, 1, 2, cyc);

    // Reset asserted while in D_WAIT of a store.
    dren = 1'b0; dwen = 4'hF; dva = 32'hA000_0040; dwd = 32'hFFFF_FFFF;
    ireq = 1'b1; iva = 32'h0000_0400;
    tick(); chk("rs_req", 32'(bus_a.mem_req), 32'd1); chk("rs_wen_on", 32'(bus_a.mem_wen), 32'hF);
    bus_a.mem_ready = 1'b1;
    tick(); bus_a.mem_ready = 1'b0; rst = 1'b1; chk("rs_wait", 32'(bus_a.mem_req), 32'd0);
    tick();
    chk("rs_stall", 32'(stall), 32'd1);
    chk("rs_req_off", 32'(bus_a.mem_req), 32'd0);
    chk("rs_wen", 32'(bus_a.mem_wen), 32'd0);
    chk("rs_wdata", bus_a.mem_wdata, 32'h0);
    chk("rs_addr", bus_a.mem_addr, 32'h0);
    chk("rs_ird", ird, 32'h0);
    chk("rs_drd", drd, 32'h0);
    rst = 1'b0; dwen = 4'h0; ireq = 1'b0; dwd = 32'h0;
    exp_ird = 32'h0; exp_drd = 32'h0;
    tick(); tick();
    run_step(1'b1, 4'h0, 32'h9000_0010, 32'h0, 1'b0, 32'h0, 0, 1, 0, 1, cyc);

    // Instruction-first instance: fetch must be issued before the load.
    b_ireq = 1'b1; b_iva = 32'h8000_0500; b_dren = 1'b1; b_dva = 32'hA000_0600;
    b_done = 1'b0;
    for (int k = 0; k < 20 && !b_done; k++) begin
      tick();
      if (bus_b.mem_req) b_addr.push_back(bus_b.mem_addr);
      if (!b_stall && b_addr.size() == 2) b_done = 1'b1;
    end
    b_ireq = 1'b0; b_dren = 1'b0;
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_count", 32'(b_addr.size()), 32'd2);
    if (b_addr.size() == 2) begin
      chk("b_first", b_addr[0], ref_paddr(32'h8000_0500));
      chk("b_second", b_addr[1], ref_paddr(32'hA000_0600));
    end
    chk("b_ird", b_ird, 32'hA5A5_0F0F);
    chk("b_drd", b_drd, 32'hA5A5_0F0F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
